// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode types: control word, opcodes, ALU/encoding enums, ID/EX payload.
package common;

  localparam int unsigned ILEN = 32;
  localparam int unsigned RIDX = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [2:0] {
    ENC_NONE, ENC_R, ENC_I, ENC_S, ENC_B, ENC_U, ENC_J
  } encoding_t;

  typedef struct packed {
    alu_op_t   alu_op;
    logic      alu_src;
    logic      mem_read;
    logic      mem_write;
    logic      reg_write;
    logic      mem_to_reg;
    logic      is_branch;
    logic      is_jump;
    encoding_t encoding;
    logic      illegal;
  } control_type;

  localparam control_type NOP_CONTROL = '0;

  typedef struct packed {
    logic              valid;
    control_type       ctrl;
    logic [ILEN-1:0]   data1;
    logic [ILEN-1:0]   data2;
    logic [ILEN-1:0]   imm;
    logic [ILEN-1:0]   pc;
    logic              cmp;
    logic [RIDX-1:0]   rs1;
    logic [RIDX-1:0]   rs2;
    logic [RIDX-1:0]   rd;
  } idex_t;

  // funct7[5] only selects SUB for register ops; shifts use it for both forms
  function automatic alu_op_t alu_from_funct(input logic [2:0] f3, input logic f7b5,
                                             input logic is_reg);
    case (f3)
      3'd0:    return (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return f7b5 ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 32x32 register file: x0 reads zero, synchronous clear, write-back bypass on reads.
module register_file #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            wr_en;

  assign wr_en = we && (waddr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) rdata1 = (wr_en && waddr == raddr1) ? wdata : regs_q[raddr1];
    if (raddr2 != '0) rdata2 = (wr_en && waddr == raddr2) ? wdata : regs_q[raddr2];
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: instruction decode, operand read, load-use detection, ID/EX register.
module decode_stage
  import common::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instruction_in,
  input  logic [31:0]     pc_in,
  input  logic            compflg_in,
  input  logic            valid_in,
  input  logic            flush,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall_out,
  output logic [XLEN-1:0] data1,
  output logic [XLEN-1:0] data2,
  output logic [31:0]     immediate_data,
  output control_type     control_out,
  output logic            compflg_out,
  output logic [31:0]     program_counter,
  output logic [4:0]      rs1_id,
  output logic [4:0]      rs2_id,
  output logic [4:0]      rd_id,
  output logic            valid_out
);

  idex_t           idex_q, idex_d;
  control_type     ctrl_c;
  logic [31:0]     imm_c;
  logic            uses_rs1_c, uses_rs2_c, hazard_c;
  logic [XLEN-1:0] rdata1, rdata2;
  logic [4:0]      rs1_f, rs2_f, rd_f;
  logic [31:0]     ins;

  assign ins   = instruction_in;
  assign rs1_f = ins[19:15];
  assign rs2_f = ins[24:20];
  assign rd_f  = ins[11:7];

  register_file #(.XLEN(XLEN), .NREGS(NREGS), .AW(5)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wb_reg_write),
    .waddr (wb_rd),
    .wdata (wb_data),
    .raddr1(rs1_f),
    .raddr2(rs2_f),
    .rdata1(rdata1),
    .rdata2(rdata2)
  );

  // Opcode decode and immediate generation
  always_comb begin
    ctrl_c = NOP_CONTROL;
    imm_c  = '0;
    case (ins[6:0])
      OPC_OP: begin
        ctrl_c.encoding  = ENC_R;
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_op    = alu_from_funct(ins[14:12], ins[30], 1'b1);
      end
      OPC_OP_IMM: begin
        ctrl_c.encoding  = ENC_I;
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.alu_op    = alu_from_funct(ins[14:12], ins[30], 1'b0);
        imm_c            = {{20{ins[31]}}, ins[31:20]};
      end
      OPC_LOAD: begin
        ctrl_c.encoding   = ENC_I;
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.alu_src    = 1'b1;
        ctrl_c.mem_read   = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        imm_c             = {{20{ins[31]}}, ins[31:20]};
      end
      OPC_STORE: begin
        ctrl_c.encoding  = ENC_S;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.mem_write = 1'b1;
        imm_c            = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      OPC_BRANCH: begin
        ctrl_c.encoding  = ENC_B;
        ctrl_c.is_branch = 1'b1;
        ctrl_c.alu_op    = ALU_SUB;
        imm_c            = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OPC_JAL: begin
        ctrl_c.encoding  = ENC_J;
        ctrl_c.is_jump   = 1'b1;
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        imm_c            = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OPC_JALR: begin
        ctrl_c.encoding  = ENC_I;
        ctrl_c.is_jump   = 1'b1;
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        imm_c            = {{20{ins[31]}}, ins[31:20]};
      end
      OPC_LUI, OPC_AUIPC: begin
        ctrl_c.encoding  = ENC_U;
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.alu_op    = (ins[6:0] == OPC_LUI) ? ALU_PASS_B : ALU_ADD;
        imm_c            = {ins[31:12], 12'b0};
      end
      default: ctrl_c.illegal = 1'b1;
    endcase
  end

  assign uses_rs1_c = ctrl_c.encoding inside {ENC_R, ENC_I, ENC_S, ENC_B};
  assign uses_rs2_c = ctrl_c.encoding inside {ENC_R, ENC_S, ENC_B};

  // Load in ID/EX whose destination the incoming instruction needs; flush overrides
  assign hazard_c = idex_q.valid && idex_q.ctrl.mem_read && (idex_q.rd != '0) && valid_in &&
                    ((uses_rs1_c && rs1_f == idex_q.rd) || (uses_rs2_c && rs2_f == idex_q.rd));
  assign stall_out = hazard_c && !flush;

  always_comb begin
    idex_d = '0;
    if (!flush && !stall_out && valid_in) begin
      idex_d.valid = 1'b1;
      idex_d.ctrl  = ctrl_c;
      idex_d.data1 = rdata1;
      idex_d.data2 = rdata2;
      idex_d.imm   = imm_c;
      idex_d.pc    = pc_in;
      idex_d.cmp   = compflg_in;
      idex_d.rs1   = rs1_f;
      idex_d.rs2   = rs2_f;
      idex_d.rd    = rd_f;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign valid_out       = idex_q.valid;
  assign control_out     = idex_q.ctrl;
  assign data1           = idex_q.data1;
  assign data2           = idex_q.data2;
  assign immediate_data  = idex_q.imm;
  assign program_counter = idex_q.pc;
  assign compflg_out     = idex_q.cmp;
  assign rs1_id          = idex_q.rs1;
  assign rs2_id          = idex_q.rs2;
  assign rd_id           = idex_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed table, corner sequences, random vs model.
module tb_decode_stage;
  import common::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, pc;
  logic        cmp, vin, fl, we;
  logic [4:0]  wrd;
  logic [31:0] wdat;
  logic        stall_out, compflg_out, valid_out;
  logic [31:0] data1, data2, immediate_data, program_counter;
  control_type control_out;
  logic [4:0]  rs1_id, rs2_id, rd_id;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .instruction_in(instr), .pc_in(pc), .compflg_in(cmp),
    .valid_in(vin), .flush(fl), .wb_reg_write(we), .wb_rd(wrd), .wb_data(wdat),
    .stall_out(stall_out), .data1(data1), .data2(data2), .immediate_data(immediate_data),
    .control_out(control_out), .compflg_out(compflg_out), .program_counter(program_counter),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id), .valid_out(valid_out)
  );

  typedef struct packed {
    logic        valid, alu_src, mem_read, mem_write, reg_write, mem_to_reg;
    logic        is_branch, is_jump, illegal, cmp;
    logic [31:0] d1, d2, imm, pc;
    logic [4:0]  rs1, rs2, rd;
  } exp_t;

  exp_t        m;          // expected ID/EX contents
  logic [31:0] rf [32];    // architectural register file model
  logic        last_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sx(input int unsigned v, input int bits);
    longint val = longint'(v);
    if (v >= (32'd1 << (bits - 1))) val = val - (64'd1 << bits);
    return 32'(val);
  endfunction

  function automatic logic [6:0] opc(input logic [31:0] i);
    return i[6:0];
  endfunction

  // Reference decode written from the ISA's field definitions
  function automatic exp_t model_dec(input logic [31:0] i);
    exp_t e = '0;
    int unsigned u = i;
    e.valid = 1'b1;
    e.rd = 5'((u >> 7) & 31); e.rs1 = 5'((u >> 15) & 31); e.rs2 = 5'((u >> 20) & 31);
    case (opc(i))
      7'h33: e.reg_write = 1;
      7'h13: begin e.reg_write = 1; e.alu_src = 1; e.imm = sx(u >> 20, 12); end
      7'h03: begin e.reg_write = 1; e.alu_src = 1; e.mem_read = 1; e.mem_to_reg = 1;
                   e.imm = sx(u >> 20, 12); end
      7'h23: begin e.mem_write = 1; e.alu_src = 1;
                   e.imm = sx(((u >> 25) << 5) | ((u >> 7) & 31), 12); end
      7'h63: begin e.is_branch = 1;
                   e.imm = sx((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                              (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13); end
      7'h6F: begin e.is_jump = 1; e.reg_write = 1; e.alu_src = 1;
                   e.imm = sx((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                              (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21); end
      7'h67: begin e.is_jump = 1; e.reg_write = 1; e.alu_src = 1; e.imm = sx(u >> 20, 12); end
      7'h37, 7'h17: begin e.reg_write = 1; e.alu_src = 1; e.imm = u & 32'hFFFFF000; end
      default: e.illegal = 1;
    endcase
    return e;
  endfunction

  function automatic logic reads_rs1(input logic [31:0] i);
    return opc(i) inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction

  function automatic logic reads_rs2(input logic [31:0] i);
    return opc(i) inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic logic [31:0] rd_reg(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (we && wrd == r) return wdat;
    return rf[r];
  endfunction

  // One clock: drive inputs, check stall mid-cycle, then check ID/EX after the edge
  task automatic step(input logic rn, input logic [31:0] i, input logic [31:0] p, input logic c,
                      input logic v, input logic f, input logic w, input logic [4:0] r,
                      input logic [31:0] d);
    exp_t  nx, dec;
    logic  exp_stall;
    rst_n = rn; instr = i; pc = p; cmp = c; vin = v; fl = f; we = w; wrd = r; wdat = d;
    #4;
    dec = model_dec(i);
    exp_stall = m.valid && m.mem_read && m.rd != 0 && v && !f &&
                ((reads_rs1(i) && dec.rs1 == m.rd) || (reads_rs2(i) && dec.rs2 == m.rd));
    chk("stall_out", 32'(stall_out), 32'(exp_stall));
    last_stall = exp_stall;
    nx = '0;
    if (rn && !f && !exp_stall && v) begin
      nx = dec; nx.d1 = rd_reg(dec.rs1); nx.d2 = rd_reg(dec.rs2); nx.pc = p; nx.cmp = c;
    end
    if (!rn) begin
      for (int k = 0; k < 32; k++) rf[k] = '0;
    end else if (w && r != 0) rf[r] = d;
    m = nx;
    @(posedge clk); #1;
    chk("valid_out", 32'(valid_out), 32'(m.valid));
    chk("alu_src", 32'(control_out.alu_src), 32'(m.alu_src));
    chk("mem_read", 32'(control_out.mem_read), 32'(m.mem_read));
    chk("mem_write", 32'(control_out.mem_write), 32'(m.mem_write));
    chk("reg_write", 32'(control_out.reg_write), 32'(m.reg_write));
    chk("mem_to_reg", 32'(control_out.mem_to_reg), 32'(m.mem_to_reg));
    chk("is_branch", 32'(control_out.is_branch), 32'(m.is_branch));
    chk("is_jump", 32'(control_out.is_jump), 32'(m.is_jump));
    chk("illegal", 32'(control_out.illegal), 32'(m.illegal));
    if (!m.valid || m.illegal) chk("ctrl_nop", 32'(control_out & ~32'(control_type'(10'h001))), 32'd0);
    chk("data1", data1, m.d1);
    chk("data2", data2, m.d2);
    chk("immediate", immediate_data, m.imm);
    chk("program_counter", program_counter, m.pc);
    chk("compflg_out", 32'(compflg_out), 32'(m.cmp));
    chk("rs1_id", 32'(rs1_id), 32'(m.rs1));
    chk("rs2_id", 32'(rs2_id), 32'(m.rs2));
    chk("rd_id", 32'(rd_id), 32'(m.rd));
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] imm;
    logic        rw, mr, mw, br, jp, src, ill;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [31:0] ri, rp;
    logic        rc, rv;
    logic [6:0]  ops [11];

    tbl[0] = '{32'h00500093, 32'h00000005, 1, 0, 0, 0, 0, 1, 0}; // addi x1,x0,5
    tbl[1] = '{32'h0000A103, 32'h00000000, 1, 1, 0, 0, 0, 1, 0}; // lw x2,0(x1)
    tbl[2] = '{32'hFE000CE3, 32'hFFFFFFF8, 0, 0, 0, 1, 0, 0, 0}; // beq x0,x0,-8
    tbl[3] = '{32'hFE20AE23, 32'hFFFFFFFC, 0, 0, 1, 0, 0, 1, 0}; // sw x2,-4(x1)
    tbl[4] = '{32'h123452B7, 32'h12345000, 1, 0, 0, 0, 0, 1, 0}; // lui x5,0x12345
    tbl[5] = '{32'h001000EF, 32'h00000800, 1, 0, 0, 0, 1, 1, 0}; // jal x1,2048
    tbl[6] = '{32'h00008067, 32'h00000000, 1, 0, 0, 0, 1, 1, 0}; // jalr x0,0(x1)
    tbl[7] = '{32'h00000073, 32'h00000000, 0, 0, 0, 0, 0, 0, 1}; // ecall: unsupported
    tbl[8] = '{32'h002101B3, 32'h00000000, 1, 0, 0, 0, 0, 0, 0}; // add x3,x2,x2

    m = '0; last_stall = 0;
    for (int k = 0; k < 32; k++) rf[k] = '0;
    rst_n = 0; instr = '0; pc = '0; cmp = 0; vin = 0; fl = 0; we = 0; wrd = '0; wdat = '0;
    @(posedge clk); #1;
    step(0, 32'h00500093, 32'h100, 0, 1, 0, 0, 0, 0);
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_ctrl", 32'(control_out), 32'd0);

    for (int n = 0; n < 9; n++) begin
      step(1, tbl[n].ins, 32'h100 + 32'(n * 4), n[0], 1, 0, 0, 0, 0);
      chk("tbl_imm", immediate_data, tbl[n].imm);
      chk("tbl_ctrl", {25'd0, control_out.reg_write, control_out.mem_read, control_out.mem_write,
                       control_out.is_branch, control_out.is_jump, control_out.alu_src,
                       control_out.illegal},
          {25'd0, tbl[n].rw, tbl[n].mr, tbl[n].mw, tbl[n].br, tbl[n].jp, tbl[n].src, tbl[n].ill});
      chk("tbl_valid", 32'(valid_out), 32'd1);
    end
    step(1, 32'h00500093, 32'h100, 0, 1, 0, 0, 0, 0);
    chk("addi_pc", program_counter, 32'h100);
    chk("addi_rd", 32'(rd_id), 32'd1);

    // Bypass: write-back and decode in the same cycle; x0 write ignored
    step(1, 32'h002101B3, 32'h200, 0, 1, 0, 1, 5'd2, 32'hDEADBEEF);
    chk("bypass_d1", data1, 32'hDEADBEEF);
    chk("bypass_d2", data2, 32'hDEADBEEF);
    step(1, 32'h000001B3, 32'h204, 0, 1, 0, 1, 5'd0, 32'h55);
    chk("x0_read", data1, 32'd0);

    // Load-use: one stall, one bubble, then the dependent add issues
    step(1, 32'h0000A103, 32'h300, 0, 1, 0, 0, 0, 0);
    step(1, 32'h002101B3, 32'h304, 0, 1, 0, 0, 0, 0);
    chk("lu_stall", 32'(last_stall), 32'd1);
    chk("lu_bubble", 32'(valid_out), 32'd0);
    step(1, 32'h002101B3, 32'h304, 0, 1, 0, 0, 0, 0);
    chk("lu_nostall", 32'(last_stall), 32'd0);
    chk("lu_issue", 32'(valid_out), 32'd1);
    chk("lu_pc", program_counter, 32'h304);

    // Flush wins over stall; fetch moves on so the add is not re-decoded
    step(1, 32'h0000A103, 32'h400, 0, 1, 0, 0, 0, 0);
    step(1, 32'h002101B3, 32'h404, 0, 1, 1, 0, 0, 0);
    chk("fl_stall", 32'(last_stall), 32'd0);
    chk("fl_bubble", 32'(valid_out), 32'd0);
    step(1, 32'h00500093, 32'h500, 0, 1, 0, 0, 0, 0);
    chk("fl_next_pc", program_counter, 32'h500);

    // Mid-stream reset clears register file; concurrent write-back dropped
    step(1, 32'h0, 32'h0, 0, 0, 0, 1, 5'd5, 32'd7);
    step(1, 32'h00028033, 32'h600, 0, 1, 0, 0, 0, 0); // add x0,x5,x0
    chk("x5_written", data1, 32'd7);
    step(0, 32'h00628033, 32'h604, 1, 1, 0, 1, 5'd6, 32'd9);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_pc", program_counter, 32'd0);
    step(1, 32'h00628033, 32'h608, 0, 1, 0, 0, 0, 0); // add x0,x5,x6
    chk("rst_x5", data1, 32'd0);
    chk("rst_x6", data2, 32'd0);

    // Random traffic; fetch holds its outputs whenever a stall was raised
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};
    ri = 32'h13; rp = 0; rc = 0; rv = 0;
    for (int n = 0; n < 600; n++) begin
      if (!last_stall) begin
        ri = $urandom;
        ri[6:0] = ops[$urandom_range(0, 10)];
        ri[11:7] = 5'($urandom_range(0, 3));
        ri[19:15] = 5'($urandom_range(0, 3));
        ri[24:20] = 5'($urandom_range(0, 3));
        rp = $urandom & 32'hFFFF_FFFE;
        rc = 1'($urandom);
        rv = ($urandom_range(0, 7) != 0);
      end
      step(($urandom_range(0, 99) != 0), ri, rp, rc, rv, ($urandom_range(0, 9) == 0),
           1'($urandom), 5'($urandom_range(0, 4)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the five-stage RV32I pipeline, sitting between fetch and execute. It decodes the fetched instruction and reads operands from an internal 32×32 register file, with same-cycle write-back bypass. It detects load-use hazards and registers everything into the ID/EX pipeline register that drives `execute_stage_if` (`data1`, `data2`, `immediate_data`, `control_in`, `compflg_in`, `program_counter`).

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `NREGS`, 32, register-file depth; x0 is hardwired to zero

Ports:
- Clock and reset: one clock, `clk`; reset `rst_n` is synchronous and active-low.
- `clk` in 1 clock
- `rst_n` in 1 synchronous active-low reset
- `instruction_in` in 32 fetched instruction, already expanded if compressed
- `pc_in` in 32 PC of `instruction_in`
- `compflg_in` in 1 instruction originated from a 16-bit compressed encoding
- `valid_in` in 1 fetch output is valid
- `flush` in 1 branch taken in execute; kill the instruction in decode
- `wb_reg_write` in 1 write-back enable
- `wb_rd` in 5 write-back destination
- `wb_data` in 32 write-back data
- `stall_out` out 1 load-use hazard; fetch must hold PC and instruction
- `data1` out 32 rs1 operand
- `data2` out 32 rs2 operand
- `immediate_data` out 32 sign-extended immediate
- `control_out` out control_type decoded control word
- `compflg_out` out 1 registered `compflg_in`
- `program_counter` out 32 registered `pc_in`
- `rs1_id`, `rs2_id`, `rd_id` out 5 each; register indices for forwarding
- `valid_out` out 1 ID/EX holds a real instruction

## Operation
- Decode: the opcode selects the immediate format and the control fields (alu_op, alu_src, mem_read, mem_write, reg_write, mem_to_reg, is_branch, is_jump, encoding).
  - Immediates are sign-extended: I, S, B (bit0=0), U (low 12 bits zero), J (bit0=0).
  - R-type yields immediate 0.
- Illegal or unsupported opcode: control word is all-zero (NOP), `valid_out`=1, and `control_out.illegal`=1.
- Register file:
  - Writes occur on the rising edge when `wb_reg_write`=1 and `wb_rd`≠0.
  - Reads are combinational.
  - Bypass: if `wb_reg_write` and `wb_rd`==rs and rs≠0, the read returns `wb_data` in the same cycle.
  - Reads of x0 always return 0.
- Load-use hazard (combinational): `stall_out`=1 when all of the following hold:
  - `valid_out` and `control_out.mem_read` are set;
  - `rd_id`≠0;
  - `valid_in` is set;
  - the current instruction reads `rd_id` as rs1, or as rs2 (R/S/B-type only).
- ID/EX register update priority, evaluated per clock edge:
  1. `!rst_n` → all outputs 0, `control_out`=NOP, `valid_out`=0
  2. `flush` → bubble: `control_out`=NOP, `valid_out`=0; data fields don't-care, driven to 0
  3. `stall_out` → bubble inserted; fetch holds, so the same instruction is re-decoded next cycle
  4. `!valid_in` → bubble
  5. otherwise → load decoded values, `valid_out`=1
- `flush` and `stall_out` in the same cycle: flush wins and `stall_out` is forced to 0.

## Timing
- Latency: `instruction_in` → ID/EX outputs, 1 cycle.
- `stall_out` is combinational from the ID/EX state and `instruction_in`; it lasts exactly one cycle per load-use pair.
- A write-back in cycle N is visible to a decode in cycle N through the bypass.
- Reset values: every output is 0; `control_out`=NOP; register file is all zeros.
- Reset asserted mid-stream clears the pipeline register and register file on the next edge. Any `wb_*` write in that cycle is dropped.
- Throughput: 1 instruction/cycle, except for load-use bubbles.

## Structure
- Package `common`: `control_type` struct, opcode constants, `alu_op_t` and `encoding_t` enums, `NOP_CONTROL` constant.
- Sub-module `register_file` (32×32, synchronous reset, bypass) instantiated once.
- Decode and immediate generation are combinational `always_comb` logic inside `decode_stage`.

## Test plan
- ADDI: `0x00500093` (addi x1,x0,5), valid, pc 0x100 → next cycle: `immediate_data`=5, reg_write=1, alu_src=imm, `rd_id`=1, `program_counter`=0x100, `valid_out`=1.
- Bypass and x0:
  - `wb_rd`=2, `wb_data`=0xDEADBEEF, same cycle decode `0x002101B3` (add x3,x2,x2) → `data1`=`data2`=0xDEADBEEF.
  - `wb_rd`=0 → x0 still reads 0.
- Load-use: `0x0000A103` (lw x2,0(x1)) then `0x002101B3` → `stall_out`=1 for one cycle, one bubble (`valid_out`=0), then the add issues with `valid_out`=1.
- B-immediate: `0xFE000CE3` (beq x0,x0,-8) → `immediate_data`=0xFFFFFFF8, is_branch=1.
- Flush during stall: load-use pair with `flush`=1 in the hazard cycle → `stall_out`=0, bubble emitted, no repeated decode.
- Reset mid-operation: write x5=7, drop `rst_n` for one cycle → all outputs 0; decode reading x5 returns 0.
